spi_serdes: RTL and testbench



---
 rtl/spi_serdes.sv | 130 +++++++++++++
 tb/tb_spi_serdes.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_serdes.sv
// SPI mode-0 slave serializer/deserializer, oversampled in the clk domain.
// Fixed-size packets in and out, MSB first, with partial-frame abort counting.
module spi_serdes #(
  parameter int PACKET_SIZE     = 40,
  parameter int SYNC_STAGES     = 2,
  parameter int ABORT_CNT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sck,
  input  logic                       mosi,
  input  logic                       cs_n,
  output logic                       miso,
  output logic                       miso_oe,
  output logic [PACKET_SIZE-1:0]     inputReg,
  output logic                       dataReady,
  input  logic [PACKET_SIZE-1:0]     toOutput,
  input  logic                       loadOutput,
  output logic [ABORT_CNT_WIDTH-1:0] abort_count
);

  localparam int CW = $clog2(PACKET_SIZE);

  logic [SYNC_STAGES-1:0]     r_sck_sync;
  logic [SYNC_STAGES-1:0]     r_mosi_sync;
  logic [SYNC_STAGES-1:0]     r_cs_sync;
  logic                       r_sck_q;
  logic                       r_cs_q;
  logic [CW-1:0]              r_bit_cnt;
  logic [PACKET_SIZE-1:0]     r_rx_shift;
  logic [PACKET_SIZE-1:0]     r_input_reg;
  logic                       r_data_ready;
  logic [ABORT_CNT_WIDTH-1:0] r_abort_cnt;
  logic [PACKET_SIZE-1:0]     r_tx_shift;
  logic                       r_miso_oe;

  logic                       w_sck_s;
  logic                       w_mosi_s;
  logic                       w_cs_s;
  logic                       w_sck_rise;
  logic                       w_sck_fall;
  logic                       w_cs_rise;
  logic                       w_cs_fall;
  logic                       w_active;
  logic                       w_last;
  logic [PACKET_SIZE-1:0]     w_rx_next;

  assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
  assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck_s & ~r_sck_q;
  assign w_sck_fall = ~w_sck_s & r_sck_q;
  assign w_cs_rise  = w_cs_s & ~r_cs_q;
  assign w_cs_fall  = ~w_cs_s & r_cs_q;
  assign w_active   = ~w_cs_s;
  assign w_last     = (r_bit_cnt == CW'(PACKET_SIZE-1));
  assign w_rx_next  = {r_rx_shift[PACKET_SIZE-2:0], w_mosi_s};

  assign miso        = r_tx_shift[PACKET_SIZE-1];
  assign miso_oe     = r_miso_oe;
  assign inputReg    = r_input_reg;
  assign dataReady   = r_data_ready;
  assign abort_count = r_abort_cnt;

  // Pin synchronizers plus one extra sck/cs stage for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sck_sync  <= '0;
      r_mosi_sync <= '0;
      r_cs_sync   <= '1;
      r_sck_q     <= 1'b0;
      r_cs_q      <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
      r_sck_q     <= w_sck_s;
      r_cs_q      <= w_cs_s;
    end
  end

  // Receive path: bit counting, packet capture and abort accounting
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bit_cnt    <= '0;
      r_rx_shift   <= '0;
      r_input_reg  <= '0;
      r_data_ready <= 1'b0;
      r_abort_cnt  <= '0;
    end else begin
      r_data_ready <= 1'b0;
      if (w_cs_fall) begin
        r_bit_cnt  <= '0;
        r_rx_shift <= '0;
      end else if (w_cs_rise) begin
        r_bit_cnt <= '0;
        if (r_bit_cnt != '0 && r_abort_cnt != '1)
          r_abort_cnt <= r_abort_cnt + ABORT_CNT_WIDTH'(1);
      end else if (w_active && w_sck_rise) begin
        r_rx_shift <= w_rx_next;
        if (w_last) begin
          r_bit_cnt    <= '0;
          r_input_reg  <= w_rx_next;
          r_data_ready <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + CW'(1);
        end
      end
    end
  end

  // Transmit shifter; a load wins over reset so the first word is ready
  always_ff @(posedge clk) begin
    if (loadOutput)
      r_tx_shift <= toOutput;
    else if (reset)
      r_tx_shift <= '0;
    else if (w_active && w_sck_fall && r_bit_cnt != '0)
      r_tx_shift <= {r_tx_shift[PACKET_SIZE-2:0], 1'b0};
  end

  // MISO driver enable follows the synchronized chip select
  always_ff @(posedge clk) begin
    if (reset)
      r_miso_oe <= 1'b0;
    else
      r_miso_oe <= ~w_cs_s;
  end

endmodule

// File: tb/tb_spi_serdes.sv
// Directed bench for spi_serdes: master model at f_clk/8 plus a
// downstream stub that reloads the TX word one clk after dataReady.
module tb_spi_serdes;

  localparam int NRND = 120;

  logic        clk = 1'b0;
  logic        reset;
  logic        sck;
  logic        mosi;
  logic        cs_n;
  logic        miso;
  logic        miso_oe;
  logic [39:0] inputReg;
  logic        dataReady;
  logic [39:0] toOutput;
  logic        loadOutput;
  logic [7:0]  abort_count;

  spi_serdes dut (
    .clk(clk), .reset(reset), .sck(sck), .mosi(mosi), .cs_n(cs_n),
    .miso(miso), .miso_oe(miso_oe), .inputReg(inputReg),
    .dataReady(dataReady), .toOutput(toOutput),
    .loadOutput(loadOutput), .abort_count(abort_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int dr_cnt = 0;
  int last_dr = 0;
  logic dr_prev = 1'b0;
  logic stub_en = 1'b0;
  int load_idx = 0;
  logic [39:0] tx_words [0:NRND];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // One clk: sample outputs #1 after the edge, run the downstream stub
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (dataReady) begin
      chk("dr_width", {63'd0, dr_prev}, 64'd0);
      dr_cnt++;
      last_dr = cyc;
    end
    if (stub_en) begin
      loadOutput = dr_prev;
      if (dr_prev) begin
        toOutput = tx_words[load_idx];
        load_idx++;
      end
    end
    dr_prev = dataReady;
  endtask

  // Master: n bits MSB-first, mosi changes on sck fall, miso sampled on rise
  task automatic send(input logic [39:0] mo, input int n,
                      output logic [39:0] mi, output int rcyc);
    mi = '0;
    rcyc = 0;
    for (int i = 0; i < n; i++) begin
      mosi = mo[39-i];
      repeat (4) tick();
      mi = {mi[38:0], miso};
      sck = 1'b1;
      rcyc = cyc;
      repeat (4) tick();
      sck = 1'b0;
    end
  endtask

  task automatic frame_start();
    cs_n = 1'b0;
    repeat (4) tick();
  endtask

  task automatic frame_end();
    cs_n = 1'b1;
    repeat (6) tick();
  endtask

  logic [39:0] mi;
  logic [39:0] mo;
  int rc;
  int dr0;

  initial begin
    reset = 1'b1;
    sck = 1'b0;
    mosi = 1'b0;
    cs_n = 1'b1;
    loadOutput = 1'b1;
    toOutput = 40'h5A_C30F_F011;
    repeat (10) tick();
    chk("rst_inputReg", {24'd0, inputReg}, 64'd0);
    chk("rst_dataReady", {63'd0, dataReady}, 64'd0);
    chk("rst_abort", {56'd0, abort_count}, 64'd0);
    chk("rst_miso_oe", {63'd0, miso_oe}, 64'd0);
    reset = 1'b0;
    loadOutput = 1'b0;
    repeat (2) tick();

    // single packet with word preloaded through reset
    frame_start();
    chk("oe_active", {63'd0, miso_oe}, 64'd1);
    dr0 = dr_cnt;
    send(40'h04_1234_5678, 40, mi, rc);
    chk("p1_miso", {24'd0, mi}, 64'h5A_C30F_F011);
    chk("p1_inputReg", {24'd0, inputReg}, 64'h04_1234_5678);
    chk("p1_dr_lat", 64'(last_dr - rc), 64'd3);
    frame_end();
    chk("p1_dr_cnt", 64'(dr_cnt - dr0), 64'd1);
    chk("oe_idle", {63'd0, miso_oe}, 64'd0);

    // three back-to-back packets, stub loads 1,2,3
    loadOutput = 1'b1;
    toOutput = 40'hC0_FFEE_1234;
    tick();
    loadOutput = 1'b0;
    tick();
    tx_words[0] = 40'd1;
    tx_words[1] = 40'd2;
    tx_words[2] = 40'd3;
    load_idx = 0;
    stub_en = 1'b1;
    dr0 = dr_cnt;
    frame_start();
    send(40'hA5_A5A5_A5A5, 40, mi, rc);
    chk("b2b_miso0", {24'd0, mi}, 64'hC0_FFEE_1234);
    chk("b2b_rx0", {24'd0, inputReg}, 64'hA5_A5A5_A5A5);
    send(40'h12_3456_789A, 40, mi, rc);
    chk("b2b_miso1", {24'd0, mi}, 64'd1);
    chk("b2b_rx1", {24'd0, inputReg}, 64'h12_3456_789A);
    send(40'hFE_DCBA_9876, 40, mi, rc);
    chk("b2b_miso2", {24'd0, mi}, 64'd2);
    chk("b2b_rx2", {24'd0, inputReg}, 64'hFE_DCBA_9876);
    frame_end();
    stub_en = 1'b0;
    loadOutput = 1'b0;
    chk("b2b_dr_cnt", 64'(dr_cnt - dr0), 64'd3);
    chk("b2b_abort", {56'd0, abort_count}, 64'd0);

    // partial frame of 17 bits, then a clean packet
    dr0 = dr_cnt;
    frame_start();
    send(40'hFF_FF00_00AB, 17, mi, rc);
    frame_end();
    chk("part_dr_cnt", 64'(dr_cnt - dr0), 64'd0);
    chk("part_abort", {56'd0, abort_count}, 64'd1);
    frame_start();
    send(40'h98_7654_3210, 40, mi, rc);
    frame_end();
    chk("after_part_rx", {24'd0, inputReg}, 64'h98_7654_3210);
    chk("after_part_abort", {56'd0, abort_count}, 64'd1);

    // abort counter climbs then saturates
    for (int k = 0; k < 300; k++) begin
      cs_n = 1'b0;
      repeat (4) tick();
      send(40'h80_0000_0000, 1, mi, rc);
      cs_n = 1'b1;
      repeat (4) tick();
      if (k == 99)
        chk("abort_101", {56'd0, abort_count}, 64'd101);
    end
    chk("abort_sat", {56'd0, abort_count}, 64'hFF);

    // sck activity with cs_n high is ignored
    dr0 = dr_cnt;
    send(40'h55_AA55_AA55, 40, mi, rc);
    repeat (6) tick();
    chk("idle_dr_cnt", 64'(dr_cnt - dr0), 64'd0);
    chk("idle_oe", {63'd0, miso_oe}, 64'd0);
    chk("idle_rx", {24'd0, inputReg}, 64'h98_7654_3210);

    // reset in the middle of a packet
    dr0 = dr_cnt;
    frame_start();
    send(40'h0F_0F0F_0F0F, 10, mi, rc);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (4) tick();
    chk("mid_rst_abort", {56'd0, abort_count}, 64'd0);
    chk("mid_rst_rx", {24'd0, inputReg}, 64'd0);
    frame_end();
    chk("mid_rst_dr_cnt", 64'(dr_cnt - dr0), 64'd0);
    chk("mid_rst_abort2", {56'd0, abort_count}, 64'd0);

    // random stream in a single frame with stub reloads
    for (int k = 0; k <= NRND; k++)
      tx_words[k] = {$urandom_range(255, 0), $urandom()};
    loadOutput = 1'b1;
    toOutput = tx_words[0];
    tick();
    loadOutput = 1'b0;
    tick();
    load_idx = 1;
    stub_en = 1'b1;
    dr0 = dr_cnt;
    frame_start();
    for (int p = 0; p < NRND; p++) begin
      mo = {$urandom_range(255, 0), $urandom()};
      send(mo, 40, mi, rc);
      chk("rnd_rx", {24'd0, inputReg}, {24'd0, mo});
      chk("rnd_miso", {24'd0, mi}, {24'd0, tx_words[p]});
      chk("rnd_dr_lat", 64'(last_dr - rc), 64'd3);
    end
    frame_end();
    stub_en = 1'b0;
    loadOutput = 1'b0;
    chk("rnd_dr_cnt", 64'(dr_cnt - dr0), 64'(NRND));
    chk("rnd_abort", {56'd0, abort_count}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
